// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART transmitter and receiver.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEFAULT = 104;
   localparam int DATA_BITS            = 8;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/uart_if.sv
// Bundles the byte-level TX request/status and RX serial/result signals of the UART.
interface uart_if;

   logic [7:0] tx_byte;
   logic       tx_start;
   logic       tx_serial;
   logic       tx_active;
   logic       tx_done;
   logic       rx_serial;
   logic       rx_dv;
   logic [7:0] rx_byte;

   modport master (
      output tx_byte, tx_start, rx_serial,
      input  tx_serial, tx_active, tx_done, rx_dv, rx_byte
   );

   modport slave (
      input  tx_byte, tx_start, rx_serial,
      output tx_serial, tx_active, tx_done, rx_dv, rx_byte
   );

   modport rx (
      input  rx_serial,
      output rx_dv, rx_byte
   );

endinterface

// File: rtl/uart_rx_engine.sv
// 8N1 receiver: two-flop line synchronizer, start-bit glitch rejection and framing-error recovery.
module uart_rx_engine
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic sysclk,
   input  logic rst_n,
   uart_if.rx   bus
);

   localparam int              CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   BIT_HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [2:0]      IDX_LAST = 3'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE      = RX_IDLE;
   localparam logic [2:0] S_START     = RX_START;
   localparam logic [2:0] S_DATA      = RX_DATA;
   localparam logic [2:0] S_STOP      = RX_STOP;
   localparam logic [2:0] S_WAIT_HIGH = RX_WAIT_HIGH;

   logic          sync1_reg;
   logic          sync2_reg;
   logic [2:0]    state_reg;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    idx_reg;
   logic [7:0]    shift_reg;
   logic [7:0]    byte_reg;
   logic          dv_reg;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
      end else begin
         sync1_reg <= bus.rx_serial;
         sync2_reg <= sync1_reg;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
         byte_reg  <= '0;
         dv_reg    <= 1'b0;
      end else begin
         dv_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               cnt_reg <= '0;
               if (!sync2_reg) state_reg <= S_START;
            end
            // Re-check half a bit in so a short low glitch never starts a frame.
            S_START: begin
               if (cnt_reg == BIT_HALF) begin
                  cnt_reg   <= '0;
                  idx_reg   <= '0;
                  state_reg <= sync2_reg ? S_IDLE : S_DATA;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_reg == BIT_LAST) begin
                  cnt_reg            <= '0;
                  shift_reg[idx_reg] <= sync2_reg;
                  if (idx_reg == IDX_LAST) state_reg <= S_STOP;
                  else                     idx_reg   <= idx_reg + 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt_reg == BIT_LAST) begin
                  cnt_reg <= '0;
                  if (sync2_reg) begin
                     byte_reg  <= shift_reg;
                     dv_reg    <= 1'b1;
                     state_reg <= S_IDLE;
                  end else begin
                     state_reg <= S_WAIT_HIGH;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               cnt_reg <= '0;
               if (sync2_reg) state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.rx_dv   = dv_reg;
   assign bus.rx_byte = byte_reg;

endmodule

// File: rtl/uart_rx_tx.sv
// 8N1 UART with an inline transmitter and an independent receiver sub-module.
module uart_rx_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic [7:0] i_Tx_Byte,
   input  logic       i_Tx_start,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Active,
   output logic       o_Tx_Done,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

   localparam logic [1:0] S_IDLE  = TX_IDLE;
   localparam logic [1:0] S_START = TX_START;
   localparam logic [1:0] S_DATA  = TX_DATA;
   localparam logic [1:0] S_STOP  = TX_STOP;

   uart_if bus ();

   assign bus.tx_byte   = i_Tx_Byte;
   assign bus.tx_start  = i_Tx_start;
   assign bus.rx_serial = i_Rx_Serial;

   logic [1:0]    tx_state_reg;
   logic [CW-1:0] tx_cnt_reg;
   logic [2:0]    tx_idx_reg;
   logic [7:0]    tx_data_reg;
   logic          tx_serial_reg;
   logic          tx_active_reg;
   logic          tx_done_reg;

   // The serial line is registered, so each state drives the level of the bit that follows it.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_reg  <= S_IDLE;
         tx_cnt_reg    <= '0;
         tx_idx_reg    <= '0;
         tx_data_reg   <= '0;
         tx_serial_reg <= 1'b1;
         tx_active_reg <= 1'b0;
         tx_done_reg   <= 1'b0;
      end else begin
         tx_done_reg <= 1'b0;
         case (tx_state_reg)
            S_IDLE: begin
               tx_cnt_reg <= '0;
               if (bus.tx_start) begin
                  tx_data_reg   <= bus.tx_byte;
                  tx_serial_reg <= 1'b0;
                  tx_active_reg <= 1'b1;
                  tx_state_reg  <= S_START;
               end
            end
            S_START: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg    <= '0;
                  tx_idx_reg    <= '0;
                  tx_serial_reg <= tx_data_reg[0];
                  tx_state_reg  <= S_DATA;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + 1'b1;
               end
            end
            S_DATA: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg <= '0;
                  if (tx_idx_reg == IDX_LAST) begin
                     tx_serial_reg <= 1'b1;
                     tx_state_reg  <= S_STOP;
                  end else begin
                     tx_idx_reg    <= tx_idx_reg + 1'b1;
                     tx_serial_reg <= tx_data_reg[tx_idx_reg + 3'd1];
                  end
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + 1'b1;
               end
            end
            S_STOP: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg    <= '0;
                  tx_active_reg <= 1'b0;
                  tx_done_reg   <= 1'b1;
                  tx_state_reg  <= S_IDLE;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + 1'b1;
               end
            end
            default: tx_state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.tx_serial = tx_serial_reg;
   assign bus.tx_active = tx_active_reg;
   assign bus.tx_done   = tx_done_reg;

   uart_rx_engine #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_engine (
      .sysclk(sysclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign o_Tx_Serial = bus.tx_serial;
   assign o_Tx_Active = bus.tx_active;
   assign o_Tx_Done   = bus.tx_done;
   assign o_Rx_DV     = bus.rx_dv;
   assign o_Rx_Byte   = bus.rx_byte;

endmodule

// File: tb/tb_uart_rx_tx.sv
// Directed bench for uart_rx_tx at 16 clocks per bit: TX waveform, loopback, RX glitch/framing and reset abort.
module tb_uart_rx_tx;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic loop_en = 1'b0;
   logic rx_drv = 1'b1;

   int checks = 0;
   int failures = 0;

   uart_if tb_bus ();

   assign tb_bus.rx_serial = loop_en ? tb_bus.tx_serial : rx_drv;

   uart_rx_tx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .sysclk     (clk),
      .rst_n      (rst_n),
      .i_Tx_Byte  (tb_bus.tx_byte),
      .i_Tx_start (tb_bus.tx_start),
      .o_Tx_Serial(tb_bus.tx_serial),
      .o_Tx_Active(tb_bus.tx_active),
      .o_Tx_Done  (tb_bus.tx_done),
      .i_Rx_Serial(tb_bus.rx_serial),
      .o_Rx_DV    (tb_bus.rx_dv),
      .o_Rx_Byte  (tb_bus.rx_byte)
   );

   always #5 clk = ~clk;

   int         dv_count = 0;
   int         done_count = 0;
   logic [7:0] dv_log [64];

   always @(negedge clk) begin
      if (tb_bus.rx_dv === 1'b1) begin
         if (dv_count < 64) dv_log[dv_count] = tb_bus.rx_byte;
         dv_count++;
      end
      if (tb_bus.tx_done === 1'b1) done_count++;
   end

   task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int n = 0; n < 10 * CPB; n++) begin
         rx_drv = frame[n / CPB];
         @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tb_bus.tx_start = 1'b0;
      tb_bus.tx_byte = 8'h00;
      rx_drv = 1'b1;
      loop_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (tb_bus.tx_serial !== 1'b1) begin failures++; $display("FAIL reset_tx_serial got=%b exp=1", tb_bus.tx_serial); end
      checks++; if (tb_bus.tx_active !== 1'b0) begin failures++; $display("FAIL reset_tx_active got=%b exp=0", tb_bus.tx_active); end
      checks++; if (tb_bus.tx_done !== 1'b0) begin failures++; $display("FAIL reset_tx_done got=%b exp=0", tb_bus.tx_done); end
      checks++; if (tb_bus.rx_dv !== 1'b0) begin failures++; $display("FAIL reset_rx_dv got=%b exp=0", tb_bus.rx_dv); end
      checks++; if (tb_bus.rx_byte !== 8'h00) begin failures++; $display("FAIL reset_rx_byte got=%h exp=00", tb_bus.rx_byte); end
      rst_n = 1'b1;
      @(negedge clk);
      $display("test_reset done");
   endtask

   // Sends one frame and checks every cycle of it; inject re-requests with another byte mid-frame.
   task automatic test_tx_frame(input logic [7:0] b, input bit inject);
      logic [9:0] frame;
      int d0;
      frame = {1'b1, b, 1'b0};
      d0 = done_count;
      tb_bus.tx_byte = b;
      tb_bus.tx_start = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 10 * CPB; n++) begin
         @(negedge clk);
         if (n == 0) tb_bus.tx_start = 1'b0;
         checks++; if (tb_bus.tx_serial !== frame[n / CPB]) begin failures++; $display("FAIL tx_serial cyc=%0d got=%b exp=%b", n, tb_bus.tx_serial, frame[n / CPB]); end
         checks++; if (tb_bus.tx_active !== 1'b1) begin failures++; $display("FAIL tx_active cyc=%0d got=%b exp=1", n, tb_bus.tx_active); end
         checks++; if (tb_bus.tx_done !== 1'b0) begin failures++; $display("FAIL tx_done_early cyc=%0d got=%b exp=0", n, tb_bus.tx_done); end
         if (inject && n == 40) begin tb_bus.tx_start = 1'b1; tb_bus.tx_byte = ~b; end
         if (inject && n == 41) tb_bus.tx_start = 1'b0;
      end
      @(negedge clk);
      checks++; if (tb_bus.tx_done !== 1'b1) begin failures++; $display("FAIL tx_done_pulse got=%b exp=1", tb_bus.tx_done); end
      checks++; if (tb_bus.tx_active !== 1'b0) begin failures++; $display("FAIL tx_active_end got=%b exp=0", tb_bus.tx_active); end
      checks++; if (tb_bus.tx_serial !== 1'b1) begin failures++; $display("FAIL tx_serial_idle got=%b exp=1", tb_bus.tx_serial); end
      @(negedge clk);
      checks++; if (tb_bus.tx_done !== 1'b0) begin failures++; $display("FAIL tx_done_width got=%b exp=0", tb_bus.tx_done); end
      checks++; if (done_count - d0 !== 1) begin failures++; $display("FAIL tx_done_count got=%0d exp=1", done_count - d0); end
      $display("test_tx_frame byte=%h inject=%0d done", b, inject);
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [4];
      int base;
      bit got;
      bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55; bytes[3] = 8'h3C;
      base = dv_count;
      loop_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tb_bus.tx_byte = bytes[i];
         tb_bus.tx_start = 1'b1;
         @(negedge clk);
         tb_bus.tx_start = 1'b0;
         got = 1'b0;
         for (int k = 0; k < 12 * CPB && !got; k++) begin
            @(negedge clk);
            if (tb_bus.tx_done === 1'b1) got = 1'b1;
         end
         checks++; if (!got) begin failures++; $display("FAIL b2b_done_timeout idx=%0d got=0 exp=1", i); end
      end
      repeat (40) @(negedge clk);
      loop_en = 1'b0;
      checks++; if (dv_count - base !== 4) begin failures++; $display("FAIL b2b_dv_count got=%0d exp=4", dv_count - base); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (dv_log[base + i] !== bytes[i]) begin failures++; $display("FAIL b2b_byte idx=%0d got=%h exp=%h", i, dv_log[base + i], bytes[i]); end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_rx_glitch();
      int base;
      base = dv_count;
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (dv_count - base !== 0) begin failures++; $display("FAIL glitch_dv got=%0d exp=0", dv_count - base); end
      checks++; if (tb_bus.rx_byte !== 8'h3C) begin failures++; $display("FAIL glitch_hold got=%h exp=3c", tb_bus.rx_byte); end
      drive_rx_frame(8'h81, 1'b1);
      repeat (40) @(negedge clk);
      checks++; if (dv_count - base !== 1) begin failures++; $display("FAIL glitch_next_dv got=%0d exp=1", dv_count - base); end
      checks++; if (dv_log[base] !== 8'h81) begin failures++; $display("FAIL glitch_next_byte got=%h exp=81", dv_log[base]); end
      $display("test_rx_glitch done");
   endtask

   task automatic test_rx_framing();
      int base;
      base = dv_count;
      drive_rx_frame(8'h3C, 1'b0);
      rx_drv = 1'b0;
      repeat (40) @(negedge clk);
      rx_drv = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (dv_count - base !== 0) begin failures++; $display("FAIL framing_dv got=%0d exp=0", dv_count - base); end
      checks++; if (tb_bus.rx_byte !== 8'h81) begin failures++; $display("FAIL framing_hold got=%h exp=81", tb_bus.rx_byte); end
      drive_rx_frame(8'h12, 1'b1);
      repeat (40) @(negedge clk);
      checks++; if (dv_count - base !== 1) begin failures++; $display("FAIL framing_next_dv got=%0d exp=1", dv_count - base); end
      checks++; if (dv_log[base] !== 8'h12) begin failures++; $display("FAIL framing_next_byte got=%h exp=12", dv_log[base]); end
      $display("test_rx_framing done");
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] frame;
      int d0, b0;
      bit got;
      frame = {1'b1, 8'h77, 1'b0};
      d0 = done_count;
      b0 = dv_count;
      loop_en = 1'b0;
      tb_bus.tx_byte = 8'h5A;
      tb_bus.tx_start = 1'b1;
      for (int n = 0; n < 50; n++) begin
         rx_drv = frame[n / CPB];
         @(negedge clk);
         if (n == 0) tb_bus.tx_start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checks++; if (tb_bus.tx_serial !== 1'b1) begin failures++; $display("FAIL rstmid_serial got=%b exp=1", tb_bus.tx_serial); end
      checks++; if (tb_bus.tx_active !== 1'b0) begin failures++; $display("FAIL rstmid_active got=%b exp=0", tb_bus.tx_active); end
      rx_drv = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (done_count - d0 !== 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", done_count - d0); end
      checks++; if (dv_count - b0 !== 0) begin failures++; $display("FAIL rstmid_dv got=%0d exp=0", dv_count - b0); end
      checks++; if (tb_bus.rx_byte !== 8'h00) begin failures++; $display("FAIL rstmid_rx_byte got=%h exp=00", tb_bus.rx_byte); end
      rst_n = 1'b1;
      loop_en = 1'b1;
      tb_bus.tx_byte = 8'h96;
      tb_bus.tx_start = 1'b1;
      @(negedge clk);
      tb_bus.tx_start = 1'b0;
      checks++; if (tb_bus.tx_active !== 1'b1) begin failures++; $display("FAIL rstmid_first_accept got=%b exp=1", tb_bus.tx_active); end
      got = 1'b0;
      for (int k = 0; k < 12 * CPB && !got; k++) begin
         @(negedge clk);
         if (tb_bus.tx_done === 1'b1) got = 1'b1;
      end
      checks++; if (!got) begin failures++; $display("FAIL rstmid_done_timeout got=0 exp=1"); end
      repeat (40) @(negedge clk);
      loop_en = 1'b0;
      checks++; if (dv_count - b0 !== 1) begin failures++; $display("FAIL rstmid_next_dv got=%0d exp=1", dv_count - b0); end
      checks++; if (tb_bus.rx_byte !== 8'h96) begin failures++; $display("FAIL rstmid_next_byte got=%h exp=96", tb_bus.rx_byte); end
      checks++; if (done_count - d0 !== 1) begin failures++; $display("FAIL rstmid_next_done got=%0d exp=1", done_count - d0); end
      $display("test_reset_mid_frame done");
   endtask

   initial begin
      test_reset();
      test_tx_frame(8'hA5, 1'b0);
      test_tx_frame(8'h3C, 1'b1);
      test_back_to_back();
      test_rx_glitch();
      test_rx_framing();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_tx.md
UART_RX_TX -- requirements
Module: uart_rx_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104 (12 MHz sysclk, 115200 baud); legal range 4..65535.
REQ-002 The block SHALL have port sysclk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_Tx_Byte, input, 8 bits: byte to transmit, sampled when a start is accepted.
REQ-005 The block SHALL have port i_Tx_start, input, 1 bit: request to transmit.
REQ-006 The block SHALL have port o_Tx_Serial, output, 1 bit: serial TX line, idle high.
REQ-007 The block SHALL have port o_Tx_Active, output, 1 bit: high while a frame is being sent.
REQ-008 The block SHALL have port o_Tx_Done, output, 1 bit: one-cycle pulse at end of frame.
REQ-009 The block SHALL have port i_Rx_Serial, input, 1 bit: asynchronous serial RX line.
REQ-010 The block SHALL have port o_Rx_DV, output, 1 bit: one-cycle pulse when a byte is received.
REQ-011 The block SHALL have port o_Rx_Byte, output, 8 bits: last received byte.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 TX SHALL accept i_Tx_start only when o_Tx_Active=0; on that edge it latches i_Tx_Byte, sets o_Tx_Active=1 and drives the start bit. Active is therefore already high one cycle after a single-cycle start pulse.
REQ-014 i_Tx_start while o_Tx_Active=1 SHALL be ignored; i_Tx_Byte changes after acceptance SHALL NOT affect the frame.
REQ-015 TX FSM states SHALL be IDLE, START, DATA (3-bit index 0..7), STOP, with transitions after each CLKS_PER_BIT count.
REQ-016 At the end of the stop bit, TX SHALL return to IDLE, drop o_Tx_Active, and pulse o_Tx_Done for exactly 1 cycle; a new start is accepted on the next cycle (back-to-back frames with zero idle gap are legal).
REQ-017 A frame SHALL occupy 10*CLKS_PER_BIT cycles from acceptance to the Done pulse.
REQ-018 RX SHALL pass i_Rx_Serial through a 2-flop synchronizer before any use.
REQ-019 RX FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-020 IDLE→START on synchronized line = 0.
REQ-021 In START, at CLKS_PER_BIT/2 (integer division) the line SHALL be re-checked: 0 → DATA; 1 → IDLE (glitch rejected, no DV).
REQ-022 DATA SHALL sample 8 bits at successive bit-midpoints (every CLKS_PER_BIT cycles) into bits 0..7.
REQ-023 STOP SHALL sample the line at the stop-bit midpoint. If 1: update o_Rx_Byte and pulse o_Rx_DV for 1 cycle, then go to IDLE. If 0 (framing error): no DV, o_Rx_Byte unchanged, go to WAIT_HIGH.
REQ-024 WAIT_HIGH→IDLE when the line = 1.
REQ-025 o_Rx_Byte SHALL hold its value until the next valid frame.
REQ-026 TX and RX SHALL operate fully independently and concurrently.
REQ-027 Bit counters SHALL be $clog2(CLKS_PER_BIT) bits wide and reset to 0 at every bit boundary, with no wrap errors at CLKS_PER_BIT-1.

Reset
REQ-028 While rst_n=0, outputs SHALL be: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Rx_DV=0, o_Rx_Byte=0x00; both FSMs in IDLE; counters 0; synchronizer flops=1.
REQ-029 Reset mid-frame SHALL abort immediately with no Done or DV pulse.
REQ-030 After release, the first start is accepted on the first rising edge with rst_n=1.

Structure
REQ-031 A shared package uart_pkg SHALL hold the default CLKS_PER_BIT, the TX and RX state enums, and the data-bit-count constant (8).
REQ-032 The receiver SHALL be a sub-module uart_rx_engine (synchronizer + RX FSM); the transmitter SHALL be inline in uart_rx_tx.

Verification (CLKS_PER_BIT=16)
REQ-033 TX 0xA5, 1-cycle start pulse → line 0,1,0,1,0,0,1,0,1,1, 16 cycles each; Active high from cycle 1; Done pulse at cycle 160.
REQ-034 Loopback o_Tx_Serial→i_Rx_Serial with bytes 0x00, 0xFF, 0x55, 0x3C sent back-to-back → 4 DV pulses with matching o_Rx_Byte and no gaps missed.
REQ-035 RX line low for 4 cycles then high → no DV; a valid 0x81 frame sent afterwards → DV with 0x81.
REQ-036 RX frame 0x3C with stop bit 0, line held low 40 more cycles, then valid frame 0x12 → only one DV, value 0x12.
REQ-037 Start pulse during an active frame with a different i_Tx_Byte → ignored; the original frame completes; exactly one Done pulse.
REQ-038 rst_n low in DATA of both TX and RX → line=1 and Active=0 immediately; no Done or DV pulse; the next frame works normally.
